// File: rtl/letc_limp_mem_responder.sv
// LIMP responder: word RAM behind a valid/ready request/response pair.
// Fixed extra response latency lets the core's stall paths be exercised.
module letc_limp_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] LAT_M1 =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          wen_q;
  logic          flt_q;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [32:0]   rel;
  logic          in_rng;
  logic          misal;
  logic          flt;
  logic          accept;
  logic          load_en;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wsh;

  logic [AW-1:0] s_idx;
  logic [1:0]    s_off;
  logic [1:0]    s_size;
  logic          s_wen;
  logic          s_flt;
  logic [31:0]   rsh;

  // 33-bit difference: an address below the base underflows past SPAN
  assign rel    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign in_rng = rel < SPAN;
  assign misal  = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign flt    = (req_size == 2'b11) || misal || !in_rng;
  assign widx   = rel[AW+1:2];

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    be = 4'b0000;
    case (req_size)
      2'b00:   be = 4'b0001 << req_addr[1:0];
      2'b01:   be = 4'b0011 << req_addr[1:0];
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wsh = req_wdata << {req_addr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst_n && accept && req_wen && !flt) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  // with zero latency RESP is entered at the accept edge itself
  assign s_idx  = (state_q == IDLE) ? widx          : idx_q;
  assign s_off  = (state_q == IDLE) ? req_addr[1:0] : off_q;
  assign s_size = (state_q == IDLE) ? req_size      : size_q;
  assign s_wen  = (state_q == IDLE) ? req_wen       : wen_q;
  assign s_flt  = (state_q == IDLE) ? flt           : flt_q;

  assign rsh = mem[s_idx] >> {s_off, 3'b000};

  always_comb begin
    rdata_d = 32'h0;
    if (!s_flt && !s_wen) begin
      unique case (1'b1)
        (s_size == 2'b00): rdata_d = {24'h0, rsh[7:0]};
        (s_size == 2'b01): rdata_d = {16'h0, rsh[15:0]};
        default:           rdata_d = rsh;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_en = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      wen_q   <= 1'b0;
      flt_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q  <= widx;
        off_q  <= req_addr[1:0];
        size_q <= req_size;
        wen_q  <= req_wen;
        flt_q  <= flt;
      end
      if (load_en) rdata_q <= rdata_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_fault = rsp_valid && flt_q;

  a_req_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (req_valid && !req_ready) |=>
      $stable({req_wen, req_size, req_addr, req_wdata})
  );

endmodule

// File: tb/tb_letc_limp_mem_responder.sv
// Directed bench: zero-latency instance at base 0 and a
// three-cycle-latency instance at base 0x8000_0000.
module tb_letc_limp_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rqv [2];
  logic        rqr [2];
  logic        rqw [2];
  logic [1:0]  rqs [2];
  logic [31:0] rqa [2];
  logic [31:0] rqd [2];
  logic        rsv [2];
  logic        rsr [2];
  logic [31:0] rsd [2];
  logic        rsf [2];

  letc_limp_mem_responder #(
    .DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rqv[0]), .req_ready(rqr[0]), .req_wen(rqw[0]),
    .req_size(rqs[0]), .req_addr(rqa[0]), .req_wdata(rqd[0]),
    .rsp_valid(rsv[0]), .rsp_ready(rsr[0]),
    .rsp_rdata(rsd[0]), .rsp_fault(rsf[0])
  );

  letc_limp_mem_responder #(
    .DEPTH_WORDS(16), .LATENCY(3), .BASE_ADDR(32'h8000_0000)
  ) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rqv[1]), .req_ready(rqr[1]), .req_wen(rqw[1]),
    .req_size(rqs[1]), .req_addr(rqa[1]), .req_wdata(rqd[1]),
    .rsp_valid(rsv[1]), .rsp_ready(rsr[1]),
    .rsp_rdata(rsd[1]), .rsp_fault(rsf[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive at posedge+1; returns one cycle after the completing edge
  task automatic txn(input int d, input logic wen, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd,
                     output logic f, output int n, output int acc);
    rqv[d] = 1'b1; rqw[d] = wen; rqs[d] = sz; rqa[d] = a; rqd[d] = wd;
    @(posedge clk); #1;
    acc = cyc;
    rqv[d] = 1'b0;
    n = 0;
    while (!rsv[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsv[d]) chk("rsp_timeout", 32'(rsv[d]), 32'd1);
    rd = rsd[d];
    f = rsf[d];
    if (hold > 0) begin
      rsr[d] = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_valid", 32'(rsv[d]), 32'd1);
        chk("hold_rdata", rsd[d], rd);
        chk("hold_ready", 32'(rqr[d]), 32'd0);
      end
      rsr[d] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        f;
  int          n, acc, prev, stray;
  logic [31:0] tbl [8];

  initial begin
    tbl[0] = 32'h0000_0001; tbl[1] = 32'h1234_5678;
    tbl[2] = 32'hFFFF_FFFF; tbl[3] = 32'h8000_0000;
    tbl[4] = 32'h0F0F_0F0F; tbl[5] = 32'hF0F0_F0F0;
    tbl[6] = 32'hA5A5_5A5A; tbl[7] = 32'h0000_0000;
    for (int d = 0; d < 2; d++) begin
      rqv[d] = 1'b0; rqw[d] = 1'b0; rqs[d] = 2'b00;
      rqa[d] = 32'h0; rqd[d] = 32'h0; rsr[d] = 1'b1;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(rqr[d]), 32'd1);
      chk("rst_valid", 32'(rsv[d]), 32'd0);
      chk("rst_rdata", rsd[d], 32'h0);
      chk("rst_fault", 32'(rsf[d]), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // word store / load, zero latency: valid sampled at edge T+1
    txn(0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 0, rd, f, n, acc);
    chk("st_lat", 32'(n + 1), 32'd1);
    chk("st_rdata", rd, 32'h0);
    chk("st_fault", 32'(f), 32'd0);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, f, n, acc);
    chk("ld_lat", 32'(n + 1), 32'd1);
    chk("ld_rdata", rd, 32'hDEAD_BEEF);
    chk("ld_fault", 32'(f), 32'd0);

    // byte and half lanes
    txn(0, 1'b1, 2'b10, 32'h10, 32'h1122_3344, 0, rd, f, n, acc);
    txn(0, 1'b1, 2'b00, 32'h13, 32'h0000_00A5, 0, rd, f, n, acc);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, f, n, acc);
    chk("lane_word", rd, 32'hA522_3344);
    txn(0, 1'b0, 2'b00, 32'h13, 32'h0, 0, rd, f, n, acc);
    chk("lane_b3", rd, 32'h0000_00A5);
    txn(0, 1'b0, 2'b00, 32'h10, 32'h0, 0, rd, f, n, acc);
    chk("lane_b0", rd, 32'h0000_0044);
    txn(0, 1'b0, 2'b01, 32'h12, 32'h0, 0, rd, f, n, acc);
    chk("lane_h1", rd, 32'h0000_A522);

    // faults leave memory untouched
    txn(0, 1'b1, 2'b10, 32'h0, 32'h0102_0304, 0, rd, f, n, acc);
    txn(0, 1'b0, 2'b01, 32'h11, 32'h0, 0, rd, f, n, acc);
    chk("flt_half_f", 32'(f), 32'd1);
    chk("flt_half_d", rd, 32'h0);
    txn(0, 1'b1, 2'b10, 32'h12, 32'hFFFF_FFFF, 0, rd, f, n, acc);
    chk("flt_word_f", 32'(f), 32'd1);
    chk("flt_word_d", rd, 32'h0);
    txn(0, 1'b1, 2'b11, 32'h10, 32'h0, 0, rd, f, n, acc);
    chk("flt_size_f", 32'(f), 32'd1);
    chk("flt_size_d", rd, 32'h0);
    txn(0, 1'b1, 2'b10, 32'h1000, 32'hEEEE_EEEE, 0, rd, f, n, acc);
    chk("flt_oor_f", 32'(f), 32'd1);
    chk("flt_oor_d", rd, 32'h0);
    txn(0, 1'b0, 2'b10, 32'h10, 32'h0, 0, rd, f, n, acc);
    chk("flt_keep10", rd, 32'hA522_3344);
    txn(0, 1'b0, 2'b10, 32'h0, 32'h0, 0, rd, f, n, acc);
    chk("flt_keep0", rd, 32'h0102_0304);

    // back-to-back, one transaction every 2 cycles
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      txn(0, i < 8, 2'b10, 32'h200 + 32'(4 * (i % 8)), tbl[i % 8], 0,
          rd, f, n, acc);
      if (i > 0) chk("b2b_period", 32'(acc - prev), 32'd2);
      if (i >= 8) chk("b2b_rdata", rd, tbl[i % 8]);
      prev = acc;
    end

    // latency 3 with a held-off response
    txn(1, 1'b1, 2'b10, 32'h8000_0008, 32'h5555_AAAA, 0, rd, f, n, acc);
    chk("l3_st_lat", 32'(n + 1), 32'd4);
    txn(1, 1'b0, 2'b10, 32'h8000_0008, 32'h0, 5, rd, f, n, acc);
    chk("l3_ld_lat", 32'(n + 1), 32'd4);
    chk("l3_rdata", rd, 32'h5555_AAAA);
    txn(1, 1'b0, 2'b10, 32'h7FFF_FFFC, 32'h0, 0, rd, f, n, acc);
    chk("l3_below_f", 32'(f), 32'd1);
    txn(1, 1'b0, 2'b10, 32'h8000_0040, 32'h0, 0, rd, f, n, acc);
    chk("l3_above_f", 32'(f), 32'd1);
    chk("l3_above_d", rd, 32'h0);

    // async reset in the middle of WAIT after an accepted store
    rqv[1] = 1'b1; rqw[1] = 1'b1; rqs[1] = 2'b10;
    rqa[1] = 32'h8000_0004; rqd[1] = 32'h0BAD_F00D;
    @(posedge clk); #1;
    rqv[1] = 1'b0;
    chk("wait_ready", 32'(rqr[1]), 32'd0);
    chk("wait_valid", 32'(rsv[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(rqr[1]), 32'd1);
    chk("arst_valid", 32'(rsv[1]), 32'd0);
    chk("arst_rdata", rsd[1], 32'h0);
    chk("arst_fault", 32'(rsf[1]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsv[1]) stray++;
    end
    chk("arst_stray", 32'(stray), 32'd0);
    txn(1, 1'b0, 2'b10, 32'h8000_0004, 32'h0, 0, rd, f, n, acc);
    chk("arst_kept", rd, 32'h0BAD_F00D);
    chk("arst_kept_f", 32'(f), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
